sample_assembler: RTL and testbench



---
 rtl/fir_uart_pkg.sv | 17 +
 rtl/gap_timer.sv | 26 ++
 rtl/sample_assembler.sv | 97 +++++++++
 tb/tb_sample_assembler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fir_uart_pkg.sv
// Shared constants and types for the UART-to-FIR sample path.
package fir_uart_pkg;

    localparam int BYTE_W   = 8;
    localparam int SAMPLE_W = 2 * BYTE_W;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115200;
    // Roughly four 10-bit byte-times at BAUD on CLK_HZ.
    localparam int GAP_CYC = 17360;

    typedef enum logic {
        WAIT_MSB = 1'b0,
        WAIT_LSB = 1'b1
    } asm_state_e;

endpackage

// File: rtl/gap_timer.sv
// Clear/enable up-counter with a terminal-count flag at GAP_CYC-1.
module gap_timer #(
    parameter int GAP_CYC = 17360,
    parameter int TMR_W   = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TMR_W-1:0] count;

    // Counter: clear has priority over enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TMR_W'(GAP_CYC - 1));

endmodule

// File: rtl/sample_assembler.sv
// Pairs MSB/LSB bytes from the UART receiver into 16-bit samples with a
// gap timeout, and holds them in a single-entry valid/ready output register.
module sample_assembler
    import fir_uart_pkg::*;
#(
    // Fixed at 2 * BYTE_W; exposed only for documentation at the instance.
    parameter int SAMPLE_W = fir_uart_pkg::SAMPLE_W,
    parameter int GAP_CYC  = fir_uart_pkg::GAP_CYC,
    parameter int TMR_W    = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    input  logic                rx_err,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    output logic                resync
);

    asm_state_e        state;
    logic [BYTE_W-1:0] msb_reg;
    logic              tmr_tc;
    logic              handshake;
    logic              complete;

    assign handshake = sample_valid & sample_ready;

    // A good byte in WAIT_LSB completes a sample; it beats a same-cycle timeout.
    always_comb begin
        complete = 1'b0;
        if (state == WAIT_LSB && rx_valid && !rx_err) begin
            complete = 1'b1;
        end
    end

    // Timer is held clear in WAIT_MSB so it starts from 0 after the MSB edge.
    gap_timer #(
        .GAP_CYC (GAP_CYC),
        .TMR_W   (TMR_W)
    ) u_gap_timer (
        .clk (clk),
        .rst (rst),
        .clr (state == WAIT_MSB),
        .en  (state == WAIT_LSB),
        .tc  (tmr_tc)
    );

    // Pairing FSM, output register and registered event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_MSB;
            msb_reg      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            resync       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            resync  <= 1'b0;

            if (handshake) begin
                sample_valid <= 1'b0;
            end
            if (complete) begin
                if (!sample_valid || handshake) begin
                    sample       <= SAMPLE_W'({msb_reg, rx_data});
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            unique case (state)
                WAIT_MSB: begin
                    if (rx_valid && !rx_err) begin
                        msb_reg <= rx_data;
                        state   <= WAIT_LSB;
                    end
                end
                WAIT_LSB: begin
                    if (rx_valid) begin
                        resync <= rx_err;
                        state  <= WAIT_MSB;
                    end else if (tmr_tc) begin
                        resync <= 1'b1;
                        state  <= WAIT_MSB;
                    end
                end
                default: state <= WAIT_MSB;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_assembler.sv
// Directed bench for sample_assembler with hand-computed expectations.
module tb_sample_assembler;

    localparam int GAP = 17360;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        resync;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;
    int rsy_cnt = 0;
    int ovr_base;
    int rsy_base;

    sample_assembler #(
        .SAMPLE_W (16),
        .GAP_CYC  (GAP),
        .TMR_W    (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_err       (rx_err),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .resync       (resync)
    );

    always #10 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
            if (resync === 1'b1)  rsy_cnt <= rsy_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte strobe; it is sampled on the edge inside tick().
    task automatic send(input logic [7:0] b, input logic err);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = err;
        tick();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        rx_err       = 1'b0;
        sample_ready = 1'b1;
        tick();
        tick();
        check("reset_sample", 32'(sample), 32'h0000);
        check("reset_valid", 32'(sample_valid), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_resync", 32'(resync), 32'd0);
        rst = 1'b0;
        tick();

        // 1: basic pair with a 6850-cycle gap.
        ovr_base = ovr_cnt;
        rsy_base = rsy_cnt;
        send(8'h01, 1'b0);
        repeat (6849) tick();
        check("t1_no_early_valid", 32'(sample_valid), 32'd0);
        send(8'h25, 1'b0);
        check("t1_valid", 32'(sample_valid), 32'd1);
        check("t1_sample", 32'(sample), 32'h0125);
        tick();
        check("t1_valid_falls", 32'(sample_valid), 32'd0);
        check("t1_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
        check("t1_no_resync", 32'(rsy_cnt - rsy_base), 32'd0);

        // 2: MSB then idle -> resync exactly GAP cycles later.
        send(8'h80, 1'b0);
        repeat (GAP - 1) tick();
        check("t2_resync_not_early", 32'(resync), 32'd0);
        tick();
        check("t2_resync", 32'(resync), 32'd1);
        check("t2_no_sample", 32'(sample_valid), 32'd0);
        tick();
        check("t2_resync_one_cycle", 32'(resync), 32'd0);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        check("t2_valid", 32'(sample_valid), 32'd1);
        check("t2_sample", 32'(sample), 32'h1234);
        tick();

        // 3: overrun while the held sample is not consumed.
        sample_ready = 1'b0;
        ovr_base = ovr_cnt;
        send(8'h01, 1'b0);
        send(8'h25, 1'b0);
        check("t3_first", 32'(sample), 32'h0125);
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b0);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_held", 32'(sample), 32'h0125);
        check("t3_held_valid", 32'(sample_valid), 32'd1);
        tick();
        check("t3_overrun_one", 32'(ovr_cnt - ovr_base), 32'd1);
        check("t3_still_held", 32'(sample), 32'h0125);
        sample_ready = 1'b1;
        tick();
        check("t3_consumed", 32'(sample_valid), 32'd0);

        // 4: framing error on the LSB.
        send(8'h55, 1'b0);
        send(8'h66, 1'b1);
        check("t4_resync", 32'(resync), 32'd1);
        check("t4_no_sample", 32'(sample_valid), 32'd0);
        send(8'h7F, 1'b0);
        send(8'hFF, 1'b0);
        check("t4_sample", 32'(sample), 32'h7FFF);
        check("t4_valid", 32'(sample_valid), 32'd1);
        tick();

        // 5: reset in WAIT_LSB with a held sample.
        sample_ready = 1'b0;
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'hEE, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_sample", 32'(sample), 32'h0000);
        check("t5_valid", 32'(sample_valid), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_resync", 32'(resync), 32'd0);
        sample_ready = 1'b1;
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        check("t5_pair", 32'(sample), 32'hA55A);
        check("t5_pair_valid", 32'(sample_valid), 32'd1);
        tick();

        // 6: LSB on the timer-expiry cycle wins.
        rsy_base = rsy_cnt;
        send(8'h11, 1'b0);
        repeat (GAP - 1) tick();
        send(8'h22, 1'b0);
        check("t6_valid", 32'(sample_valid), 32'd1);
        check("t6_sample", 32'(sample), 32'h1122);
        check("t6_resync_now", 32'(resync), 32'd0);
        tick();
        tick();
        check("t6_no_resync", 32'(rsy_cnt - rsy_base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
